// File: rtl/counter_event_pkg.sv
// counter_event_pkg
// Shared widths and the event record layout for the counter-stage event logger.
// No ports. It provides:
//   TS_W / STOP_W / SEQ_W  default field widths
//   FIFO_DEPTH / FIFO_AW   default buffer depth and its log2
//   counter_event_t        packed record {ts, stop, seq}
package counter_event_pkg;

  localparam int TS_W       = 16;
  localparam int STOP_W     = 8;
  localparam int SEQ_W      = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int FIFO_AW    = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic [TS_W-1:0]   ts;
    logic [STOP_W-1:0] stop;
    logic [SEQ_W-1:0]  seq;
  } counter_event_t;

  localparam int EVENT_W = $bits(counter_event_t);

endpackage

// File: rtl/counter_event_logger_if.sv
// counter_event_logger_if
// Valid/ready event drain port.
//   evt_valid  head entry valid (producer -> consumer)
//   evt_ready  consumer accepts the head (consumer -> producer)
//   evt_ts     head timestamp
//   evt_stop   head stop value
//   evt_seq    head sequence number
// Modports:
//   master  the logger side
//   slave   the consumer side
interface counter_event_logger_if #(
  parameter int TS_WIDTH   = counter_event_pkg::TS_W,
  parameter int STOP_WIDTH = counter_event_pkg::STOP_W,
  parameter int SEQ_WIDTH  = counter_event_pkg::SEQ_W
);
  logic                  evt_valid;
  logic                  evt_ready;
  logic [TS_WIDTH-1:0]   evt_ts;
  logic [STOP_WIDTH-1:0] evt_stop;
  logic [SEQ_WIDTH-1:0]  evt_seq;

  modport master (output evt_valid, evt_ts, evt_stop, evt_seq, input evt_ready);
  modport slave  (input evt_valid, evt_ts, evt_stop, evt_seq, output evt_ready);
endinterface

// File: rtl/counter_event_logger_event_fifo.sv
// event_fifo
// Generic synchronous first-word-fall-through FIFO.
// Ports:
//   clk, reset_l  clock and asynchronous active-low reset
//   push, din     write request and data (ignored when full without a pop)
//   pop           read request (ignored when empty)
//   dout          head entry, valid whenever empty=0
//   full, empty   occupancy flags, both registered-state only
module event_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_l,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/counter_event_logger.sv
// counter_event_logger
// Watches the counter stage's done level, logs each enabled rising edge as
// {timestamp, stop, sequence} into a FWFT FIFO and drains it over valid/ready.
// Ports:
//   clk, reset_l  clock and asynchronous active-low reset
//   enable        event detection enable (draining continues when low)
//   done          counter stage done level
//   stop          counter stage stop value, captured with each event
//   overflow      sticky flag: at least one event was dropped
//   clear_ovf     clears overflow on the next edge (a same-cycle drop wins)
//   evt           event drain port (master side)
module counter_event_logger
  import counter_event_pkg::*;
#(
  parameter int STOP_WIDTH = STOP_W,
  parameter int TS_WIDTH   = TS_W,
  parameter int SEQ_WIDTH  = SEQ_W,
  parameter int DEPTH      = FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  reset_l,
  input  logic                  enable,
  input  logic                  done,
  input  logic [STOP_WIDTH-1:0] stop,
  output logic                  overflow,
  input  logic                  clear_ovf,
  counter_event_logger_if.master evt
);
  localparam int ENTRY_W = TS_WIDTH + STOP_WIDTH + SEQ_WIDTH;

  logic [TS_WIDTH-1:0]  ts;
  logic [SEQ_WIDTH-1:0] seq;
  logic                 done_q;
  logic                 det;
  logic                 pop;
  logic                 drop;
  logic                 full;
  logic                 empty;
  logic [ENTRY_W-1:0]   head;

  assign det  = enable & done & ~done_q;
  assign pop  = ~empty & evt.evt_ready;
  assign drop = det & full & ~pop;

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      ts       <= '0;
      seq      <= '0;
      done_q   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      ts     <= ts + TS_WIDTH'(1);
      done_q <= done;
      // Sequence advances on every detected edge, stored or not, so drops
      // show up as gaps at the consumer.
      if (det) seq <= seq + SEQ_WIDTH'(1);
      if (drop)           overflow <= 1'b1;
      else if (clear_ovf) overflow <= 1'b0;
    end
  end

  event_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_l (reset_l),
    .push    (det),
    .din     ({ts, stop, seq}),
    .pop     (pop),
    .dout    (head),
    .full    (full),
    .empty   (empty)
  );

  assign evt.evt_valid = ~empty;
  assign evt.evt_seq   = head[SEQ_WIDTH-1:0];
  assign evt.evt_stop  = head[SEQ_WIDTH +: STOP_WIDTH];
  assign evt.evt_ts    = head[SEQ_WIDTH+STOP_WIDTH +: TS_WIDTH];
endmodule

// File: tb/tb_counter_event_logger.sv
// tb_counter_event_logger
// Directed scenarios plus randomized traffic against a queue-based reference
// of the event logger: timestamp = cycles since reset release, events are
// appended on enabled rising edges, dropped (and flagged) when the buffer
// is full and nothing leaves that cycle.
module tb_counter_event_logger;
  import counter_event_pkg::*;

  logic       clk = 1'b0;
  logic       reset_l = 1'b1;
  logic       enable = 1'b0;
  logic       done = 1'b0;
  logic       clear_ovf = 1'b0;
  logic [7:0] stop = 8'h00;
  logic       overflow;

  int checks = 0;
  int failures = 0;

  counter_event_logger_if ev ();

  counter_event_logger dut (
    .clk       (clk),
    .reset_l   (reset_l),
    .enable    (enable),
    .done      (done),
    .stop      (stop),
    .overflow  (overflow),
    .clear_ovf (clear_ovf),
    .evt       (ev)
  );

  always #5 clk = ~clk;

  // reference state
  logic [15:0]    m_ts;
  logic [7:0]     m_seq;
  bit             m_ovf;
  bit             m_prev;
  counter_event_t m_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("valid", {31'd0, ev.evt_valid}, {31'd0, m_q.size() != 0});
    if (m_q.size() != 0) begin
      chk("ts",   {16'd0, ev.evt_ts},   {16'd0, m_q[0].ts});
      chk("stop", {24'd0, ev.evt_stop}, {24'd0, m_q[0].stop});
      chk("seq",  {24'd0, ev.evt_seq},  {24'd0, m_q[0].seq});
    end
    chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
  endtask

  // One clock: drive inputs, advance the reference, then check at the negedge.
  task automatic step(input bit en, input bit dn, input logic [7:0] st,
                      input bit rdy, input bit clr, input bit do_chk);
    counter_event_t e;
    bit rising, drop;
    enable = en; done = dn; stop = st; ev.evt_ready = rdy; clear_ovf = clr;
    rising = en && dn && !m_prev;
    drop = 1'b0;
    if (m_q.size() != 0 && rdy) void'(m_q.pop_front());
    if (rising) begin
      e.ts = m_ts; e.stop = st; e.seq = m_seq;
      if (m_q.size() < FIFO_DEPTH) m_q.push_back(e);
      else drop = 1'b1;
      m_seq = m_seq + 8'd1;
    end
    if (drop) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    m_prev = dn;
    m_ts = m_ts + 16'd1;
    @(posedge clk);
    @(negedge clk);
    if (do_chk) check_outputs();
  endtask

  // Called at a negedge; checks the asynchronous clear before any clock edge.
  task automatic do_reset();
    enable = 0; done = 0; stop = 0; ev.evt_ready = 0; clear_ovf = 0;
    reset_l = 1'b0;
    #1;
    chk("rst_valid", {31'd0, ev.evt_valid}, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    chk("rst_fields", {ev.evt_ts, ev.evt_stop, ev.evt_seq}, 32'd0);
    m_q.delete();
    m_ts = 16'd0; m_seq = 8'd0; m_ovf = 1'b0; m_prev = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset_l = 1'b1;
  endtask

  initial begin
    ev.evt_ready = 1'b0;
    @(negedge clk);

    // single event at ts=10, consumed immediately
    do_reset();
    while (m_ts != 16'd10) step(1, 0, 8'h00, 1, 0, 1);
    step(1, 1, 8'h5A, 1, 0, 1);
    chk("t1_ts",  {16'd0, ev.evt_ts},  32'd10);
    chk("t1_seq", {24'd0, ev.evt_seq}, 32'd0);
    step(1, 0, 8'h00, 1, 0, 1);
    chk("t1_one_cycle", {31'd0, ev.evt_valid}, 32'd0);

    // six edges with consumer stalled: four kept, overflow set, seq gap
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(1, 1, 8'(i + 1), 0, 0, 1);
      step(1, 0, 8'h00, 0, 0, 1);
    end
    chk("t2_ovf", {31'd0, overflow}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk("t2_seq", {24'd0, ev.evt_seq}, i);
      step(1, 0, 8'h00, 1, 0, 1);
    end
    step(1, 0, 8'h00, 1, 1, 1);
    chk("t2_clr", {31'd0, overflow}, 32'd0);
    step(1, 1, 8'h77, 1, 0, 1);
    chk("t2_next_seq", {24'd0, ev.evt_seq}, 32'd6);

    // full FIFO with simultaneous pop and push: no drop
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 8'(8'h10 + i), 0, 0, 1);
      step(1, 0, 8'h00, 0, 0, 1);
    end
    step(1, 1, 8'hC3, 1, 0, 1);
    chk("t3_no_ovf", {31'd0, overflow}, 32'd0);
    for (int i = 0; i < 5; i++) step(1, 0, 8'h00, 1, 0, 1);

    // done held high gives one event; disabled edge is not logged
    do_reset();
    for (int i = 0; i < 20; i++) step(1, 1, 8'h21, 1, 0, 1);
    for (int i = 0; i < 2; i++) step(1, 0, 8'h00, 1, 0, 1);
    step(0, 1, 8'h22, 1, 0, 1);
    step(0, 1, 8'h22, 1, 0, 1);
    step(0, 0, 8'h00, 1, 0, 1);
    step(1, 1, 8'h23, 0, 0, 1);
    chk("t4_seq", {24'd0, ev.evt_seq}, 32'd1);
    step(1, 0, 8'h00, 1, 0, 1);

    // timestamp wrap
    do_reset();
    while (m_ts != 16'hFFFF) step(1, 0, 8'h00, 1, 0, 0);
    step(1, 1, 8'hAA, 0, 0, 1);
    chk("t5_ts_ffff", {16'd0, ev.evt_ts}, 32'h0000FFFF);
    step(1, 0, 8'h00, 0, 0, 1);
    step(1, 1, 8'hBB, 1, 0, 1);
    chk("t5_ts_0001", {16'd0, ev.evt_ts}, 32'h00000001);
    step(1, 0, 8'h00, 1, 0, 1);

    // reset with entries queued and overflow set
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1, 1, 8'(8'h30 + i), 0, 0, 1);
      step(1, 0, 8'h00, 0, 0, 1);
    end
    do_reset();
    step(1, 1, 8'h44, 0, 0, 1);
    chk("t6_seq0", {24'd0, ev.evt_seq}, 32'd0);

    // randomized traffic
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 7) != 0, 1'($urandom_range(0, 1)), 8'($urandom),
           $urandom_range(0, 1) != 0, $urandom_range(0, 15) == 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
